// File: rtl/aplic_src_conditioner.sv
// Per-source conditioning of raw device interrupt wires: synchronize, glitch-filter,
// detect filtered edges and keep a sticky event record for the APLIC source inputs.
module aplic_src_conditioner #(
  parameter int NR_SRC      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              ni_rst,
  input  logic [NR_SRC-1:0] i_sources,
  input  logic [NR_SRC-1:0] i_en,
  input  logic [NR_SRC-1:0] i_clr,
  output logic [NR_SRC-1:0] o_level,
  output logic [NR_SRC-1:0] o_rise,
  output logic [NR_SRC-1:0] o_fall,
  output logic [NR_SRC-1:0] o_event
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][NR_SRC-1:0] sync_q, sync_d;
  logic [NR_SRC-1:0]                  sync_s;
  logic [NR_SRC-1:0]                  filt_q, filt_d;
  logic [NR_SRC-1:0]                  filt_dly_q, filt_dly_d;
  logic [NR_SRC-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [NR_SRC-1:0]                  event_q, event_d;
  logic [NR_SRC-1:0]                  rise, fall;

  // Stage 0 captures the raw wire; the oldest stage is the usable synchronous value.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_sources};
  assign sync_s = sync_q[SYNC_STAGES-1];

  // A mismatch must persist FILT_CYCLES consecutive edges; any agreeing cycle restarts it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NR_SRC; i++) begin
      if (!i_en[i]) begin
        filt_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Forcing the delayed copy low with the level keeps a disable from looking like a fall.
  assign filt_dly_d = filt_q & i_en;

  assign rise = filt_q & ~filt_dly_q;
  assign fall = ~filt_q & filt_dly_q;

  // A pulse in the same cycle as a clear takes priority over the clear.
  assign event_d = (event_q & ~i_clr) | rise | fall;

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      sync_q     <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '0;
      event_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      cnt_q      <= cnt_d;
      event_q    <= event_d;
    end
  end

  assign o_level = filt_q;
  assign o_rise  = rise;
  assign o_fall  = fall;
  assign o_event = event_q | rise | fall;

endmodule

// File: tb/tb_aplic_src_conditioner.sv
// Bench for aplic_src_conditioner: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_aplic_src_conditioner;

  localparam int NR   = 32;
  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic          i_clk = 1'b0;
  logic          ni_rst = 1'b0;
  logic [NR-1:0] i_sources = '0;
  logic [NR-1:0] i_en = '0;
  logic [NR-1:0] i_clr = '0;
  logic [NR-1:0] o_level, o_rise, o_fall, o_event;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  aplic_src_conditioner #(
    .NR_SRC(NR), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT)
  ) dut (
    .i_clk(i_clk), .ni_rst(ni_rst), .i_sources(i_sources), .i_en(i_en),
    .i_clr(i_clr), .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_event(o_event)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // Raw samples age through a delay queue; a source's level flips once its
  // synchronized value has disagreed for FILT edges since the last agreement.
  logic [NR-1:0] pipe[$];
  logic [NR-1:0] m_f, m_fd, m_ev;
  int            m_last[NR];
  int            edge_n = 0;

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < SYNC; k++) pipe.push_front('0);
    m_f  = '0;
    m_fd = '0;
    m_ev = '0;
    for (int i = 0; i < NR; i++) m_last[i] = edge_n;
  endtask

  task automatic model_step();
    logic [NR-1:0] s, r, f, nf, nfd;
    s = pipe[SYNC-1];
    r = m_f & ~m_fd;
    f = ~m_f & m_fd;
    m_ev = (m_ev & ~i_clr) | r | f;
    edge_n++;
    nf  = m_f;
    nfd = m_f;
    for (int i = 0; i < NR; i++) begin
      if (!i_en[i]) begin
        nf[i]  = 1'b0;
        nfd[i] = 1'b0;
        m_last[i] = edge_n;
      end else if (s[i] == m_f[i]) begin
        m_last[i] = edge_n;
      end else if (edge_n - m_last[i] >= FILT) begin
        nf[i] = s[i];
        m_last[i] = edge_n;
      end
    end
    m_f  = nf;
    m_fd = nfd;
    pipe.push_front(i_sources);
    void'(pipe.pop_back());
  endtask

  always @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [NR-1:0] act, input logic [NR-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (run_cmp) begin
      chk("model_level", o_level, m_f);
      chk("model_rise",  o_rise,  m_f & ~m_fd);
      chk("model_fall",  o_fall,  ~m_f & m_fd);
      chk("model_event", o_event, m_ev | (m_f & ~m_fd) | (~m_f & m_fd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic edge_sample();
    @(posedge i_clk);
    #1;
  endtask

  task automatic random_phase(input int cycles, input int lo, input int hi, input bit wild);
    int hold[NR];
    for (int i = 0; i < NR; i++) hold[i] = $urandom_range(hi, lo);
    repeat (cycles) begin
      @(negedge i_clk);
      for (int i = 0; i < NR; i++) begin
        if (hold[i] == 0) begin
          i_sources[i] = ~i_sources[i];
          hold[i] = $urandom_range(hi, lo);
        end else begin
          hold[i]--;
        end
      end
      if (wild) begin
        i_clr = $urandom & $urandom;
        i_en  = i_en ^ ($urandom & $urandom & $urandom & $urandom);
      end else begin
        i_clr = '0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit seen;
    model_reset();
    run_cmp = 1'b1;
    #3;
    chk("reset_level", o_level, '0);
    chk("reset_event", o_event, '0);
    @(negedge i_clk);
    i_en = '1;
    ni_rst = 1'b1;
    edge_sample();
    chk("post_release_outputs", o_level | o_rise | o_fall | o_event, '0);
    idle(10);

    // Source 3 rises after exactly SYNC+FILT = 6 edges.
    i_sources[3] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      edge_sample();
      if (e == 5) chk("src3_level_e5", o_level[3], 1'b0);
      if (e == 6) begin
        chk("src3_level_e6", o_level[3], 1'b1);
        chk("src3_rise_e6",  o_rise[3],  1'b1);
        chk("src3_event_e6", o_event[3], 1'b1);
      end
      if (e == 7) begin
        chk("src3_rise_e7",  o_rise[3],  1'b0);
        chk("src3_event_e7", o_event[3], 1'b1);
      end
    end

    // Source 5: 3-cycle glitch is rejected.
    @(negedge i_clk);
    i_sources[5] = 1'b1;
    idle(3);
    i_sources[5] = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 12; e++) begin
      edge_sample();
      if (o_level[5] || o_rise[5] || o_event[5]) seen = 1'b1;
    end
    chk("src5_glitch_rejected", seen, 1'b0);

    // Source 7: clear during the fall pulse loses to the set.
    @(negedge i_clk);
    i_sources[7] = 1'b1;
    idle(8);
    i_clr[7] = 1'b1;
    idle(1);
    i_clr[7] = 1'b0;
    idle(1);
    chk("src7_pre_event", o_event[7], 1'b0);
    i_sources[7] = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < 20 && !seen; e++) begin
      edge_sample();
      if (o_fall[7]) begin
        seen = 1'b1;
        i_clr[7] = 1'b1;
      end
    end
    chk("src7_fall_seen", seen, 1'b1);
    edge_sample();
    chk("src7_event_set_wins", o_event[7], 1'b1);
    edge_sample();
    chk("src7_event_cleared", o_event[7], 1'b0);
    i_clr[7] = 1'b0;

    // Source 2: disable drops the level with no fall; re-enable requalifies in 4 edges.
    @(negedge i_clk);
    i_sources[2] = 1'b1;
    idle(8);
    chk("src2_high", o_level[2], 1'b1);
    i_en[2] = 1'b0;
    edge_sample();
    chk("src2_disabled_level", o_level[2], 1'b0);
    chk("src2_no_fall", o_fall[2], 1'b0);
    edge_sample();
    chk("src2_no_fall_later", o_fall[2], 1'b0);
    @(negedge i_clk);
    i_en[2] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      edge_sample();
      if (e == 3) chk("src2_reen_e3", o_level[2], 1'b0);
      if (e == 4) chk("src2_reen_e4", o_level[2], 1'b1);
    end

    // Source 0: reset mid-qualification discards the partial count.
    @(negedge i_clk);
    i_sources[0] = 1'b1;
    for (int e = 0; e < 4; e++) edge_sample();
    #1;
    ni_rst = 1'b0;
    #1;
    chk("async_rst_level", o_level, '0);
    chk("async_rst_event", o_event, '0);
    chk("async_rst_pulses", o_rise | o_fall, '0);
    idle(2);
    ni_rst = 1'b1;
    k = 0;
    for (int e = 1; e <= 6; e++) begin
      edge_sample();
      if (e == 5) chk("src0_post_rst_e5", o_level[0], 1'b0);
      if (e == 6) chk("src0_post_rst_e6", o_level[0], 1'b1);
    end

    // Random stable periods >= FILT on all sources, then glitchy traffic with clears/enables.
    random_phase(800, 4, 12, 1'b0);
    random_phase(800, 1, 6, 1'b1);
    @(negedge i_clk);
    i_en  = '1;
    i_clr = '0;
    idle(20);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aplic_src_conditioner.md
APLIC_SRC_CONDITIONER -- requirements
Module: aplic_src_conditioner

Interface
REQ-001 The block SHALL have parameter NR_SRC, default 32, giving the number of interrupt source wires conditioned (1..1023).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (legal 2..4).
REQ-003 The block SHALL have parameter FILT_CYCLES, default 4, giving the glitch-filter length in cycles (legal 1..255).
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 ni_rst  input  1  asynchronous, active-low reset.
REQ-006 i_sources  input  NR_SRC  raw, asynchronous interrupt wires from devices.
REQ-007 i_en  input  NR_SRC  per-source enable; 0 holds that source's conditioning inactive.
REQ-008 i_clr  input  NR_SRC  per-source clear of the sticky event bit, sampled each cycle.
REQ-009 o_level  output  NR_SRC  filtered, synchronous level; feeds the APLIC interrupt source inputs.
REQ-010 o_rise  output  NR_SRC  one-cycle pulse on a filtered 0->1 transition.
REQ-011 o_fall  output  NR_SRC  one-cycle pulse on a filtered 1->0 transition.
REQ-012 o_event  output  NR_SRC  sticky record of any filtered transition since last clear.

Function
REQ-013 Each i_sources bit SHALL pass through a SYNC_STAGES-deep flop chain; the chain output is the synchronized value s[i].
REQ-014 Each source SHALL hold a filtered level f[i] and a counter c[i] of width clog2(FILT_CYCLES+1).
REQ-015 When s[i]==f[i], c[i] SHALL be loaded with 0.
REQ-016 When s[i]!=f[i] and c[i]<FILT_CYCLES-1, c[i] SHALL increment by 1.
REQ-017 When s[i]!=f[i] and c[i]==FILT_CYCLES-1, f[i] SHALL take s[i] and c[i] SHALL load 0 in the same edge.
REQ-018 Any cycle with s[i]==f[i] during counting SHALL restart the count from 0 (glitch rejection; no partial credit).
REQ-019 o_level[i] SHALL equal f[i] directly from a flop, with no combinational path from i_sources.
REQ-020 A raw level change held stable SHALL reach o_level exactly SYNC_STAGES+FILT_CYCLES rising edges after it is first sampled.
REQ-021 A registered copy f_d[i] SHALL be kept; o_rise[i]=f[i]&~f_d[i] and o_fall[i]=~f[i]&f_d[i], each high for exactly one cycle per transition.
REQ-022 o_event[i] SHALL set in the cycle o_rise[i] or o_fall[i] is high and SHALL clear on the edge after i_clr[i]=1.
REQ-023 If set and i_clr[i] coincide in one cycle, set SHALL win and o_event[i] SHALL remain 1.
REQ-024 When i_en[i]=0, f[i], f_d[i] and c[i] SHALL be forced to 0 each edge; the synchronizer chain SHALL keep running; o_event[i] SHALL hold unless cleared.
REQ-025 Disabling a source whose f[i]=1 SHALL produce no o_fall pulse (f and f_d fall together).
REQ-026 On re-enable, a source whose s[i]=1 SHALL require a full FILT_CYCLES qualification before o_level rises.
REQ-027 Sources SHALL be fully independent; no event on one bit SHALL affect another bit's state.

Reset
REQ-028 On ni_rst=0, all synchronizer flops, f, f_d, c and o_event SHALL go to 0 immediately, without waiting for a clock edge.
REQ-029 While in reset, and in the first cycle after release, o_level, o_rise, o_fall and o_event SHALL be 0.
REQ-030 Reset asserted mid-qualification SHALL discard the partial count; after release, qualification SHALL restart from 0.

Verification
REQ-031 Defaults; i_en=all 1; i_sources[3] 0->1 held -> o_level[3] rises exactly 6 edges later; o_rise[3] high 1 cycle; o_event[3]=1.
REQ-032 i_sources[5] high for 3 cycles then low (FILT_CYCLES=4) -> o_level[5], o_rise[5], o_event[5] stay 0.
REQ-033 Source 7 filtered high; drive i_clr[7]=1 in the cycle o_fall[7] pulses -> o_event[7] stays 1; clear alone next cycle -> 0 on the following edge.
REQ-034 Source 2 filtered high; i_en[2]=0 -> o_level[2]=0 next edge, no o_fall; re-enable with input high -> o_level[2]=1 after 4 edges.
REQ-035 Source 0 counter at 2; assert ni_rst asynchronously -> all outputs 0 at once; release with input high -> o_level[0]=1 after 6 edges.
REQ-036 All 32 sources toggled together with random stable periods >=4 -> each o_level matches a reference model per bit, with zero cross-talk.
